// File: rtl/instr_mem_responder.sv
// Memory-side responder for the CPU fetch/load path: single-port RAM behind valid/ready request and
// response channels with WAIT_CYCLES wait states. Define INSTR_MEM_RESP_ERR_EN to flag out-of-range addresses.
module instr_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_we
`ifdef INSTR_MEM_RESP_ERR_EN
  ,
  output logic              rsp_err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_we_q, rsp_we_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              mem_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wdata;
  logic [IDX_W-1:0]  acc_idx;

  assign accept = req_valid & req_ready;

  // With zero wait states the RAM is accessed on the accept edge, so the live request feeds it directly.
  always_comb begin
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_addr  = req_addr;
      acc_we    = req_we;
      acc_wdata = req_wdata;
    end
    acc_idx = IDX_W'({1'b0, acc_addr} % DEPTH_EXT);
  end

  assign enter_resp = ((state_q == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == S_IDLE) && !reset;
    rsp_valid = (state_q == S_RESP);
    rsp_data  = rsp_data_q;
    rsp_we    = rsp_we_q;
  end

`ifdef INSTR_MEM_RESP_ERR_EN
  logic acc_oor;
  logic rsp_err_q, rsp_err_d;

  assign acc_oor = ({1'b0, acc_addr} >= DEPTH_EXT);
  assign mem_wr  = enter_resp && acc_we && !acc_oor && !reset;
  assign rsp_err = rsp_err_q;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d = acc_oor;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      rsp_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  assign mem_wr = enter_resp && acc_we && !reset;
`endif

  // Request latch and response register; writes echo their data, reads sample the RAM.
  always_comb begin
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_we_d   = rsp_we_q;
    if (accept) begin
      addr_d  = req_addr;
      we_d    = req_we;
      wdata_d = req_wdata;
    end
    if (enter_resp) begin
      rsp_we_d   = acc_we;
      rsp_data_d = acc_we ? acc_wdata : mem[acc_idx];
`ifdef INSTR_MEM_RESP_ERR_EN
      if (acc_oor) begin
        rsp_data_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_we_q   <= rsp_we_d;
    end
  end

  // RAM contents survive reset so a preloaded program is kept.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: three instances (WAIT 1/DEPTH 16, WAIT 0, WAIT 4) share one
// driver and one monitor selected by sel; expected responses are queued at issue and checked on handshake.
module tb_instr_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_ready;
  logic [1:0] sel;

  logic [2:0] vld;
  logic [2:0] i_req_ready;
  logic [2:0] i_rsp_valid;
  logic [2:0] i_rsp_we;
  logic [7:0] i_rsp_data [3];
`ifdef INSTR_MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
  logic [2:0] i_rsp_err;
  logic       s_err;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       s_ready, s_valid, s_we;
  logic [7:0] s_data;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       we;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vld[0] = req_valid && (sel == 2'd0);
  assign vld[1] = req_valid && (sel == 2'd1);
  assign vld[2] = req_valid && (sel == 2'd2);

  instr_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(i_req_ready[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(i_rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_data(i_rsp_data[0]), .rsp_we(i_rsp_we[0])
`ifdef INSTR_MEM_RESP_ERR_EN
    , .rsp_err(i_rsp_err[0])
`endif
  );

  instr_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(i_req_ready[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(i_rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_data(i_rsp_data[1]), .rsp_we(i_rsp_we[1])
`ifdef INSTR_MEM_RESP_ERR_EN
    , .rsp_err(i_rsp_err[1])
`endif
  );

  instr_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(i_req_ready[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(i_rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_data(i_rsp_data[2]), .rsp_we(i_rsp_we[2])
`ifdef INSTR_MEM_RESP_ERR_EN
    , .rsp_err(i_rsp_err[2])
`endif
  );

  always_comb begin
    s_ready = i_req_ready[0];
    s_valid = i_rsp_valid[0];
    s_we    = i_rsp_we[0];
    s_data  = i_rsp_data[0];
`ifdef INSTR_MEM_RESP_ERR_EN
    s_err   = i_rsp_err[0];
`endif
    case (sel)
      2'd1: begin
        s_ready = i_req_ready[1];
        s_valid = i_rsp_valid[1];
        s_we    = i_rsp_we[1];
        s_data  = i_rsp_data[1];
`ifdef INSTR_MEM_RESP_ERR_EN
        s_err   = i_rsp_err[1];
`endif
      end
      2'd2: begin
        s_ready = i_req_ready[2];
        s_valid = i_rsp_valid[2];
        s_we    = i_rsp_we[2];
        s_data  = i_rsp_data[2];
`ifdef INSTR_MEM_RESP_ERR_EN
        s_err   = i_rsp_err[2];
`endif
      end
      default: ;
    endcase
  end

  function automatic int wait_of(input logic [1:0] s);
    return (s == 2'd1) ? 0 : ((s == 2'd2) ? 4 : 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request; queue its expected response unless push is 0. acc = cycle count just before accept edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input bit push,
                       input logic [7:0] exp_data, input logic exp_err, output int acc);
    int   budget;
    exp_t e;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    budget = 0;
    while (!s_ready && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!s_ready) begin
      chk("accept_timeout", {31'b0, s_ready}, 32'd1);
      req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      if (push) begin
        e.data = exp_data;
        e.we   = we;
        e.err  = exp_err;
        e.acc  = cyc;
        e.lat  = wait_of(sel) + 1;
        sb.push_back(e);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    #1;
    while ((sb.size() != 0 || s_valid) && b < 100) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  // Monitor: latency on each rising rsp_valid, payload on each handshake.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (s_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%02h, expected no response (cycle %0d)", s_data, cyc);
        end else begin
          chk("latency", cyc - sb[0].acc, sb[0].lat);
        end
      end
      if (s_valid && rsp_ready && sb.size() != 0) begin
        mon_e = sb.pop_front();
        $display("rsp sel=%0d data=0x%02h we=%0d (expected data=0x%02h we=%0d)", sel, s_data, s_we, mon_e.data, mon_e.we);
        chk("rsp_data", s_data, mon_e.data);
        chk("rsp_we", s_we, mon_e.we);
`ifdef INSTR_MEM_RESP_ERR_EN
        chk("rsp_err", s_err, mon_e.err);
`endif
      end
      prev_v = s_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int prev;
    int b;
    logic seen;
    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    sel = 2'd0;

    // Reset held three cycles, then released
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("ready_in_reset", i_req_ready[i], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ready_after_reset", i_req_ready[i], 32'd1);
      chk("valid_after_reset", i_rsp_valid[i], 32'd0);
      chk("data_after_reset", i_rsp_data[i], 32'd0);
    end

    // Write then read, one wait state
    sel = 2'd0;
    issue(1'b1, 8'h10, 8'hA5, 1'b1, 8'hA5, 1'b0, a);
    issue(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0, a);
    drain();

    // Back-pressure holds the response frozen
    rsp_ready = 1'b0;
    issue(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0, a);
    b = 0;
    #1;
    while (!s_valid && b < 20) begin
      @(negedge clk);
      #1;
      b++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", s_valid, 32'd1);
      chk("bp_data", s_data, 32'hA5);
      chk("bp_req_ready", s_ready, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_ready", s_ready, 32'd1);
    chk("bp_release_valid", s_valid, 32'd0);

    // Zero-wait sweep: one transaction every two cycles
    sel = 2'd1;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 8'(i), 8'(i + 8'h30), 1'b1, 8'(i + 8'h30), 1'b0, a);
      if (prev >= 0) chk("throughput", a - prev, 32'd2);
      prev = a;
    end
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 8'(i), 8'h00, 1'b1, 8'(i + 8'h30), 1'b0, a);
      chk("throughput", a - prev, 32'd2);
      prev = a;
    end
    drain();

    // Reset during wait states abandons the write
    sel = 2'd2;
    issue(1'b1, 8'h20, 8'h11, 1'b1, 8'h11, 1'b0, a);
    drain();
    issue(1'b1, 8'h20, 8'h55, 1'b0, 8'h00, 1'b0, a);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (s_valid) seen = 1'b1;
    end
    chk("abandoned_no_rsp", seen, 32'd0);
    issue(1'b0, 8'h20, 8'h00, 1'b1, 8'h11, 1'b0, a);
    drain();

    // Out-of-range address on the 16-word instance
    sel = 2'd0;
    issue(1'b1, 8'h03, 8'h3C, 1'b1, 8'h3C, 1'b0, a);
    issue(1'b1, 8'h13, 8'h77, 1'b1, ERR_EN ? 8'h00 : 8'h77, ERR_EN, a);
    issue(1'b0, 8'h03, 8'h00, 1'b1, ERR_EN ? 8'h3C : 8'h77, 1'b0, a);
    issue(1'b0, 8'h13, 8'h00, 1'b1, ERR_EN ? 8'h00 : 8'h77, ERR_EN, a);
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
